// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer: full throughput with in_ready and out_valid
// decoded purely from registered state, isolating out_ready from in_ready.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and data-register load selection; flush wins over everything.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State, data and output-decode flops; outputs are registered copies of the decode.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state     <= EMPTY;
      out_data  <= RESET_VAL;
      skid_q    <= RESET_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= 2'(state_nxt);
      if (load_main_in) begin
        out_data <= in_data;
      end else if (load_main_skid) begin
        out_data <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand sequences and random
// traffic checked against a two-deep FIFO queue model.
module tb_pipe_skid_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  // Reference: words held, oldest first; capacity two.
  logic [W-1:0] q[$];

  typedef struct {
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         exp_out_valid;
    logic         exp_in_ready;
    logic [1:0]   exp_occ;
    logic         chk_data;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string name);
    check({name, "_ov"}, 32'(out_valid), 32'(q.size() != 0));
    check({name, "_ir"}, 32'(in_ready), 32'(q.size() < 2));
    check({name, "_occ"}, 32'(occupancy), 32'(q.size()));
    if (q.size() != 0) check({name, "_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock edge: advance the model from pre-edge inputs, then compare after the edge.
  task automatic step(input string name);
    bit           ir;
    bit           ov;
    bit           fi;
    bit           fo;
    bit           fl;
    logic [W-1:0] d;
    ir = (q.size() < 2);
    ov = (q.size() != 0);
    fi = in_valid && ir;
    fo = ov && out_ready;
    fl = flush;
    d  = in_data;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(d);
    end
    #1;
    model_check(name);
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [W-1:0] id,
                              input logic ordy, input logic eov, input logic eir,
                              input logic [1:0] eocc, input logic cd, input logic [W-1:0] ed);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
    v.exp_out_valid = eov; v.exp_in_ready = eir; v.exp_occ = eocc;
    v.chk_data = cd; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    bit hold;

    // Directed vectors: expected outputs after the edge on which the inputs are applied.
    vecs.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 2'd1, 1, 8'hA5)); // first word after reset
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 2'd0, 1, 8'hA5)); // drain, main keeps value
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 1, 2'd1, 1, 8'h11)); // backpressure
    vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 2'd2, 1, 8'h11));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 2'd2, 1, 8'h11)); // 0x33 held off
    vecs.push_back(mk(0, 1, 8'h33, 1, 1, 1, 2'd1, 1, 8'h22)); // skid to main
    vecs.push_back(mk(0, 1, 8'h33, 1, 1, 1, 2'd1, 1, 8'h33));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 2'd0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h44, 0, 1, 1, 2'd1, 1, 8'h44)); // simultaneous in ONE
    vecs.push_back(mk(0, 1, 8'h55, 1, 1, 1, 2'd1, 1, 8'h55));
    vecs.push_back(mk(0, 1, 8'h66, 0, 1, 0, 2'd2, 1, 8'h55)); // FULL
    vecs.push_back(mk(1, 1, 8'h77, 1, 0, 1, 2'd0, 1, 8'h55)); // flush, data kept
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 2'd0, 0, 8'h00)); // 0x77 never shows

    // Reset with random inputs.
    rst = 1'b1;
    flush = 1'($urandom); in_valid = 1'($urandom); in_data = W'($urandom); out_ready = 1'($urandom);
    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    repeat (2) begin
      @(posedge clk);
      flush = 1'($urandom); in_valid = 1'($urandom); in_data = W'($urandom); out_ready = 1'($urandom);
      #1;
      check("rst_hold_ov", 32'(out_valid), 32'd0);
      check("rst_hold_data", 32'(out_data), 32'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();

    foreach (vecs[i]) begin
      flush = vecs[i].flush; in_valid = vecs[i].in_valid;
      in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      step("vec_model");
      check("vec_ov", 32'(out_valid), 32'(vecs[i].exp_out_valid));
      check("vec_ir", 32'(in_ready), 32'(vecs[i].exp_in_ready));
      check("vec_occ", 32'(occupancy), 32'(vecs[i].exp_occ));
      if (vecs[i].chk_data) check("vec_data", 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Streaming at full rate.
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      in_data = W'(w);
      step("stream_model");
      check("stream_data", 32'(out_data), 32'(w));
      check("stream_ir", 32'(in_ready), 32'd1);
      check("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
    end
    in_valid = 1'b0;
    step("stream_drain");

    // Mid-stream asynchronous reset while FULL.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h81;
    step("mrst_fill1");
    in_data = 8'h82;
    step("mrst_fill2");
    check("mrst_full", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_ir", 32'(in_ready), 32'd1);
    check("mrst_occ", 32'(occupancy), 32'd0);
    check("mrst_data", 32'(out_data), 32'h00);
    q.delete();
    #1 rst = 1'b0;
    in_data = 8'h90;
    step("mrst_accept");
    check("mrst_accept_data", 32'(out_data), 32'h90);
    check("mrst_accept_ov", 32'(out_valid), 32'd1);

    // Random traffic; a held-off offer stays stable until accepted.
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      hold      = in_valid && (q.size() >= 2);
      step("rand");
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
